// File: rtl/bus_cycle_initiator.sv
// ---------------------------------------------------------------------------
// bus_cycle_initiator
//
// Bus master that runs one 8-bit 68030-style asynchronous bus cycle at a time
// for an internal requester (DMA or debug engine). It drives nAS/nDS/RnW and
// waits for the responder to terminate with nDsack or nBerr. It then negates
// the strobes and waits for the responder to release its acknowledge. A
// watchdog turns a missing acknowledge into a bus error.
//
// Ports
//   sysClk, sysReset         clock, synchronous active-high reset
//   reqValid/reqReady        request handshake (reqReady high only in IDLE)
//   reqAddr/reqWrite/reqWData  request address, direction, write data
//   respValid                one-cycle completion pulse
//   respRData/respBerr       read data / error flag, valid with respValid
//   busAddr/busDataOut/busDataOe/busDataIn  bus address and data
//   nAS/nDS/rnw              bus strobes (active low) and direction
//   nDsack[1:0]/nBerr        asynchronous termination inputs (active low)
// ---------------------------------------------------------------------------
module bus_cycle_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              sysClk,
   input  logic              sysReset,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic              reqWrite,
   input  logic [7:0]        reqWData,
   output logic              respValid,
   output logic [7:0]        respRData,
   output logic              respBerr,
   output logic [ADDR_W-1:0] busAddr,
   output logic [7:0]        busDataOut,
   output logic              busDataOe,
   input  logic [7:0]        busDataIn,
   output logic              nAS,
   output logic              nDS,
   output logic              rnw,
   input  logic [1:0]        nDsack,
   input  logic              nBerr
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_WAIT,
      ST_RELEASE,
      ST_RECOVER
   } state_e;

   // The same limit bounds both WAIT and RECOVER. The counter starts at 0 in
   // the first cycle of each state, so TIMEOUT_CYCLES cycles have elapsed
   // when it reads TIMEOUT_CYCLES-1.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;

   // Two-flop synchronisers for the asynchronous termination inputs.
   logic [1:0]        dsack_meta_q, dsack_meta_d;
   logic [1:0]        dsack_sync_q, dsack_sync_d;
   logic              berr_meta_q, berr_meta_d;
   logic              berr_sync_q, berr_sync_d;

   logic              nas_q, nas_d;
   logic              nds_q, nds_d;
   logic              rnw_q, rnw_d;
   logic              oe_q, oe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic              resp_valid_q, resp_valid_d;
   logic [7:0]        resp_rdata_q, resp_rdata_d;
   logic              resp_berr_q, resp_berr_d;

   logic              ack_seen;
   logic              berr_seen;
   logic              released;

   assign ack_seen  = ~&dsack_sync_q;
   assign berr_seen = ~berr_sync_q;
   assign released  = (dsack_sync_q == 2'b11) && berr_sync_q;

   always_comb begin
      // NOTE: every *_d defaults to its *_q before the case statement, so
      // no path leaves a signal unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      dsack_meta_d = nDsack;
      dsack_sync_d = dsack_meta_q;
      berr_meta_d  = nBerr;
      berr_sync_d  = berr_meta_q;
      nas_d        = nas_q;
      nds_d        = nds_q;
      rnw_d        = rnw_q;
      oe_d         = oe_q;
      addr_d       = addr_q;
      dout_d       = dout_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_berr_d  = resp_berr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (reqValid) begin
               addr_d  = reqAddr;
               rnw_d   = ~reqWrite;
               dout_d  = reqWData;
               oe_d    = reqWrite;
               state_d = ST_ASSERT;
            end
         end

         ST_ASSERT: begin
            // Reads strobe nDS together with nAS. Writes hold nDS off for
            // one cycle so the data is settled on the bus before it is
            // strobed.
            nas_d   = 1'b0;
            nds_d   = ~rnw_q;
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            nds_d = 1'b0;
            cnt_d = cnt_q + 16'd1;
            if (berr_seen || ack_seen || (cnt_q == CNT_LAST)) begin
               nas_d        = 1'b1;
               nds_d        = 1'b1;
               oe_d         = 1'b0;
               resp_valid_d = 1'b1;
               // A bus error wins over a simultaneous acknowledge. A
               // timeout, where neither input is seen, is also reported
               // as an error.
               resp_berr_d  = berr_seen || !ack_seen;
               if (ack_seen && !berr_seen && rnw_q) begin
                  resp_rdata_d = busDataIn;
               end
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            cnt_d   = '0;
            state_d = ST_RECOVER;
         end

         ST_RECOVER: begin
            cnt_d = cnt_q + 16'd1;
            if (released || (cnt_q == CNT_LAST)) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments. Every flop then
   // samples pre-edge values, whatever the statement order.
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         dsack_meta_q <= 2'b11;
         dsack_sync_q <= 2'b11;
         berr_meta_q  <= 1'b1;
         berr_sync_q  <= 1'b1;
         nas_q        <= 1'b1;
         nds_q        <= 1'b1;
         rnw_q        <= 1'b1;
         oe_q         <= 1'b0;
         addr_q       <= '0;
         dout_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_berr_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dsack_meta_q <= dsack_meta_d;
         dsack_sync_q <= dsack_sync_d;
         berr_meta_q  <= berr_meta_d;
         berr_sync_q  <= berr_sync_d;
         nas_q        <= nas_d;
         nds_q        <= nds_d;
         rnw_q        <= rnw_d;
         oe_q         <= oe_d;
         addr_q       <= addr_d;
         dout_q       <= dout_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_berr_q  <= resp_berr_d;
      end
   end

   assign reqReady   = (state_q == ST_IDLE);
   assign respValid  = resp_valid_q;
   assign respRData  = resp_rdata_q;
   assign respBerr   = resp_berr_q;
   assign busAddr    = addr_q;
   assign busDataOut = dout_q;
   assign busDataOe  = oe_q;
   assign nAS        = nas_q;
   assign nDS        = nds_q;
   assign rnw        = rnw_q;

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_initiator
//
// Scoreboard bench. The stimulus process issues requests and programs a bus
// responder for each one. At issue time it computes the expected completion
// (error flag, read data, latency, strobe length, recovery time) from the
// cycle rules. A monitor process watches the bus and the response port and
// compares against the queued expectation.
// ---------------------------------------------------------------------------
module tb_bus_cycle_initiator;

   localparam int T  = 16;
   localparam int AW = 32;

   typedef enum int {M_ACK, M_BERR, M_BOTH, M_NONE} mode_e;

   typedef struct {
      mode_e      mode;
      int         delay;
      int         hold;
      logic [7:0] rdata;
      logic [1:0] pat;
   } rsp_cfg_t;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic          berr;
      logic [7:0]    rdata;
      int            lat;
      int            as_cycles;
      int            gap;
      int            acc_cyc;
   } exp_t;

   logic          sysClk;
   logic          sysReset;
   logic          reqValid;
   logic          reqReady;
   logic [AW-1:0] reqAddr;
   logic          reqWrite;
   logic [7:0]    reqWData;
   logic          respValid;
   logic [7:0]    respRData;
   logic          respBerr;
   logic [AW-1:0] busAddr;
   logic [7:0]    busDataOut;
   logic          busDataOe;
   logic [7:0]    busDataIn;
   logic          nAS;
   logic          nDS;
   logic          rnw;
   logic [1:0]    nDsack;
   logic          nBerr;

   bus_cycle_initiator #(
      .TIMEOUT_CYCLES(T),
      .ADDR_W        (AW)
   ) dut (
      .sysClk    (sysClk),
      .sysReset  (sysReset),
      .reqValid  (reqValid),
      .reqReady  (reqReady),
      .reqAddr   (reqAddr),
      .reqWrite  (reqWrite),
      .reqWData  (reqWData),
      .respValid (respValid),
      .respRData (respRData),
      .respBerr  (respBerr),
      .busAddr   (busAddr),
      .busDataOut(busDataOut),
      .busDataOe (busDataOe),
      .busDataIn (busDataIn),
      .nAS       (nAS),
      .nDS       (nDS),
      .rnw       (rnw),
      .nDsack    (nDsack),
      .nBerr     (nBerr)
   );

   initial sysClk = 1'b0;
   always #20 sysClk = ~sysClk;

   int cyc = 0;
   always @(posedge sysClk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   rsp_cfg_t   rsp_q[$];
   exp_t       sb[$];
   logic [7:0] model_rdata = 8'h00;
   bit         rsp_busy    = 1'b0;
   bit         gap_pending = 1'b0;
   int         gap_start   = 0;
   int         gap_exp     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus responder: it terminates each cycle as the stimulus programmed it.
   initial begin : responder
      rsp_cfg_t c;
      nDsack    = 2'b11;
      nBerr     = 1'b1;
      busDataIn = 8'h00;
      forever begin
         @(negedge sysClk);
         if (!nAS && rsp_q.size() > 0) begin
            c = rsp_q.pop_front();
            rsp_busy = 1'b1;
            repeat (c.delay) @(negedge sysClk);
            if (c.mode != M_NONE) begin
               busDataIn = c.rdata;
               if (c.mode != M_BERR) nDsack = c.pat;
               if (c.mode != M_ACK)  nBerr  = 1'b0;
            end
            for (int k = 0; k < 200 && !nAS; k++) @(negedge sysClk);
            if (c.mode != M_NONE) repeat (c.hold) @(negedge sysClk);
            nDsack    = 2'b11;
            nBerr     = 1'b1;
            busDataIn = 8'($urandom);
            rsp_busy  = 1'b0;
         end
      end
   end

   // Monitor: compares the bus and the responses against the scoreboard.
   initial begin : monitor
      exp_t e;
      int   as_cnt;
      as_cnt = 0;
      forever begin
         @(negedge sysClk);
         if (sysReset) begin
            as_cnt      = 0;
            gap_pending = 1'b0;
         end else begin
            if (!nAS || respValid) check("req_ready_busy", reqReady, 0);
            if (!nAS && sb.size() > 0) begin
               e = sb[0];
               check("bus_addr", busAddr, e.addr);
               check("rnw", rnw, !e.write);
               check("data_oe", busDataOe, e.write);
               if (e.write) check("data_out", busDataOut, e.wdata);
               check("nds_timing", nDS, (e.write && as_cnt == 0));
            end
            if (!nAS) as_cnt++;
            if (respValid) begin
               if (sb.size() == 0) begin
                  check("unexpected_resp", respValid, 0);
               end else begin
                  e = sb.pop_front();
                  check("resp_berr", respBerr, e.berr);
                  check("resp_rdata", respRData, e.rdata);
                  check("latency", cyc - e.acc_cyc, e.lat);
                  check("nas_low_cycles", as_cnt, e.as_cycles);
                  check("release_strobes", {nAS, nDS}, 2'b11);
                  check("release_oe", busDataOe, 0);
                  check("release_addr", busAddr, e.addr);
                  check("release_rnw", rnw, !e.write);
                  gap_pending = 1'b1;
                  gap_start   = cyc;
                  gap_exp     = e.gap;
               end
            end
            if (nAS) as_cnt = 0;
            if (gap_pending && !respValid) begin
               if (reqReady) begin
                  check("recover_gap", cyc - gap_start, gap_exp);
                  gap_pending = 1'b0;
               end else if (cyc - gap_start > 4 * T) begin
                  check("recover_gap_bound", cyc - gap_start, gap_exp);
                  gap_pending = 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!(reqReady && !rsp_busy && !gap_pending) && n < 300) begin
         @(negedge sysClk);
         n++;
      end
      check("ready_wait_bound", (n < 300), 1);
   endtask

   // Issues one request and, when expect_resp is set, queues the expected
   // completion derived from the cycle rules.
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [7:0] wd,
                        input mode_e m, input int d, input int h, input logic [7:0] rd,
                        input logic [1:0] pat, input bit expect_resp);
      rsp_cfg_t c;
      exp_t     e;
      wait_ready();
      c.mode  = m;
      c.delay = d;
      c.hold  = h;
      c.rdata = rd;
      c.pat   = pat;
      rsp_q.push_back(c);
      if (expect_resp) begin
         e.write   = wr;
         e.addr    = a;
         e.wdata   = wd;
         e.acc_cyc = cyc;
         if (m == M_ACK) begin
            e.berr = 1'b0;
            if (!wr) model_rdata = rd;
         end else begin
            e.berr = 1'b1;
         end
         e.rdata = model_rdata;
         if (m == M_NONE) begin
            e.lat       = T + 2;
            e.as_cycles = T;
            e.gap       = 2;
         end else begin
            e.lat       = d + 5;
            e.as_cycles = d + 3;
            e.gap       = (h + 3 < T + 1) ? h + 3 : T + 1;
         end
         sb.push_back(e);
      end
      reqValid = 1'b1;
      reqAddr  = a;
      reqWrite = wr;
      reqWData = wd;
      @(negedge sysClk);
      reqValid = 1'b0;
      reqAddr  = AW'($urandom);
      reqWrite = 1'($urandom);
      reqWData = 8'($urandom);
   endtask

   initial begin : stimulus
      mode_e      m;
      logic [1:0] pat;
      int         r;
      int         h;
      sysReset = 1'b1;
      reqValid = 1'b0;
      reqAddr  = '0;
      reqWrite = 1'b0;
      reqWData = 8'h00;
      repeat (3) @(negedge sysClk);
      check("rst_nas", nAS, 1);
      check("rst_nds", nDS, 1);
      check("rst_rnw", rnw, 1);
      check("rst_oe", busDataOe, 0);
      check("rst_addr", busAddr, 0);
      check("rst_dout", busDataOut, 0);
      check("rst_resp_valid", respValid, 0);
      check("rst_rdata", respRData, 0);
      check("rst_berr", respBerr, 0);
      check("rst_ready", reqReady, 1);
      sysReset = 1'b0;
      @(negedge sysClk);

      // Directed cycles
      issue(1'b0, 32'h0038_0000, 8'h00, M_ACK,  3, 0,  8'hA5, 2'b10, 1'b1);
      issue(1'b1, 32'h0038_0001, 8'h3C, M_ACK,  1, 0,  8'h00, 2'b10, 1'b1);
      issue(1'b0, 32'h0038_0002, 8'h00, M_NONE, 0, 0,  8'h00, 2'b11, 1'b1);
      issue(1'b0, 32'h0038_0003, 8'h00, M_BOTH, 2, 10, 8'h77, 2'b10, 1'b1);
      issue(1'b0, 32'h0038_0004, 8'h00, M_ACK,  0, 0,  8'h5A, 2'b01, 1'b1);

      // Reset in the middle of WAIT aborts the cycle without a response.
      issue(1'b1, 32'h0012_3456, 8'hC3, M_NONE, 0, 0, 8'h00, 2'b11, 1'b0);
      for (int k = 0; k < 10 && nAS; k++) @(negedge sysClk);
      check("reset_test_nas_low", nAS, 0);
      repeat (3) @(negedge sysClk);
      sysReset = 1'b1;
      @(negedge sysClk);
      check("midrst_nas", nAS, 1);
      check("midrst_nds", nDS, 1);
      check("midrst_oe", busDataOe, 0);
      check("midrst_ready", reqReady, 1);
      check("midrst_resp_valid", respValid, 0);
      check("midrst_rdata", respRData, 0);
      sysReset    = 1'b0;
      model_rdata = 8'h00;
      @(negedge sysClk);
      issue(1'b0, 32'h0038_0010, 8'h00, M_BERR, 1, 0, 8'h99, 2'b11, 1'b1);
      issue(1'b0, 32'h0038_0011, 8'h00, M_ACK,  2, 1, 8'h3E, 2'b00, 1'b1);

      // The responder holds nDsack far beyond the RECOVER limit.
      issue(1'b1, 32'h0038_0020, 8'hE7, M_ACK, 0, 40, 8'h00, 2'b10, 1'b1);
      issue(1'b0, 32'h0038_0021, 8'h00, M_ACK, 4, 0,  8'h81, 2'b10, 1'b1);

      // Randomised cycles
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            6:       m = M_BERR;
            7:       m = M_BOTH;
            8:       m = M_NONE;
            default: m = M_ACK;
         endcase
         case ($urandom_range(0, 2))
            0:       pat = 2'b10;
            1:       pat = 2'b01;
            default: pat = 2'b00;
         endcase
         h = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
         issue(1'($urandom), AW'($urandom), 8'($urandom), m,
               $urandom_range(0, 10), h, 8'($urandom), pat, 1'b1);
      end

      for (int k = 0; k < 300 && (sb.size() != 0 || gap_pending || rsp_busy); k++)
         @(negedge sysClk);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
